// File: rtl/halfpel_tap6_filter.sv
// Six-tap (1,-5,20,20,-5,1) half-pel interpolator over a raster pixel stream.
// Four-stage pipeline, global stall on enable, rounded unclipped signed output.
module halfpel_tap6_filter #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic                 row_start,
  input  logic [DATAWIDTH-1:0] in_pixel,
  output logic                 out_valid,
  output logic [DATAWIDTH+1:0] out_sample
);

  localparam int AW = DATAWIDTH + 1;
  localparam int SW = DATAWIDTH + 7;
  localparam int OW = DATAWIDTH + 2;

  logic [DATAWIDTH-1:0]   tap_r [6];
  logic [2:0]             cnt_r;
  logic [2:0]             cnt_next_s;
  logic                   acc_s;
  logic                   win_s;
  logic                   v1_r;
  logic                   v2_r;
  logic                   v3_r;
  logic [AW-1:0]          a_r;
  logic [AW-1:0]          b_r;
  logic [AW-1:0]          c_r;
  logic signed [SW-1:0]   a_ext_s;
  logic signed [SW-1:0]   b_ext_s;
  logic signed [SW-1:0]   c_ext_s;
  logic signed [SW-1:0]   sum_s;
  logic signed [SW-1:0]   s_r;
  logic signed [SW-1:0]   rnd_s;

  assign acc_s = enable & in_valid;

  // Fill counter next value: restarts at 1 on a new row, saturates at 6.
  always_comb begin
    cnt_next_s = cnt_r;
    if (row_start) begin
      cnt_next_s = 3'd1;
    end else if (cnt_r == 3'd6) begin
      cnt_next_s = 3'd6;
    end else begin
      cnt_next_s = cnt_r + 3'd1;
    end
  end

  // Old-row pixels stay in the taps; the counter alone decides window validity.
  assign win_s = acc_s & (cnt_next_s == 3'd6);

  // Stage 1: tap shift register, fill counter and window-valid token.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) tap_r[i] <= {DATAWIDTH{1'b0}};
      cnt_r <= 3'd0;
      v1_r  <= 1'b0;
    end else if (enable) begin
      v1_r <= win_s;
      if (in_valid) begin
        for (int i = 0; i < 5; i++) tap_r[i] <= tap_r[i+1];
        tap_r[5] <= in_pixel;
        cnt_r    <= cnt_next_s;
      end
    end
  end

  // Stage 2: symmetric pair sums.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_r  <= {AW{1'b0}};
      b_r  <= {AW{1'b0}};
      c_r  <= {AW{1'b0}};
      v2_r <= 1'b0;
    end else if (enable) begin
      a_r  <= AW'(tap_r[0]) + AW'(tap_r[5]);
      b_r  <= AW'(tap_r[1]) + AW'(tap_r[4]);
      c_r  <= AW'(tap_r[2]) + AW'(tap_r[3]);
      v2_r <= v1_r;
    end
  end

  // Weighting by shift-add: 5b = 4b + b, 20c = 16c + 4c.
  assign a_ext_s = $signed({{(SW-AW){1'b0}}, a_r});
  assign b_ext_s = $signed({{(SW-AW){1'b0}}, b_r});
  assign c_ext_s = $signed({{(SW-AW){1'b0}}, c_r});
  assign sum_s   = a_ext_s - ((b_ext_s <<< 3'd2) + b_ext_s)
                 + ((c_ext_s <<< 3'd4) + (c_ext_s <<< 3'd2));

  // Stage 3: weighted tap sum.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_r  <= {SW{1'b0}};
      v3_r <= 1'b0;
    end else if (enable) begin
      s_r  <= sum_s;
      v3_r <= v2_r;
    end
  end

  assign rnd_s = s_r + $signed({{(SW-5){1'b0}}, 5'b10000});

  // Stage 4: round-to-floor output; sample holds between results.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sample <= {OW{1'b0}};
    end else if (enable) begin
      out_valid <= v3_r;
      if (v3_r) begin
        out_sample <= OW'(rnd_s >>> 3'd5);
      end
    end
  end

endmodule

// File: tb/tb_halfpel_tap6_filter.sv
// Bench for halfpel_tap6_filter: directed vector table with exact latency,
// a stall sequence, and randomized traffic against a row-buffer reference model.
module tb_halfpel_tap6_filter;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic       row_start;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [9:0] out_sample;

  halfpel_tap6_filter #(.DATAWIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .row_start  (row_start),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;
  int row_q[$];
  int exp_q[$];

  typedef struct {
    logic       rst;
    logic       en;
    logic       iv;
    logic       rs;
    logic [7:0] px;
    logic       ev;
    int         es;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Filter value of the six most recent pixels of the current row.
  function automatic int ref_sample();
    int n;
    int s;
    n = row_q.size();
    s = row_q[n-6] - 5*row_q[n-5] + 20*row_q[n-4] + 20*row_q[n-3] - 5*row_q[n-2] + row_q[n-1];
    return (s + 16) >>> 5;
  endfunction

  task automatic step(input logic rst, input logic en, input logic iv,
                      input logic rs, input logic [7:0] px);
    logic [10:0] pre;
    pre       = {out_valid, out_sample};
    reset     = rst;
    enable    = en;
    in_valid  = iv;
    row_start = rs;
    in_pixel  = px;
    if (rst) begin
      row_q.delete();
      exp_q.delete();
    end else if (en && iv) begin
      if (rs) row_q.delete();
      row_q.push_back(int'(px));
      if (row_q.size() > 6) void'(row_q.pop_front());
      if (row_q.size() == 6) exp_q.push_back(ref_sample());
    end
    @(posedge clock);
    #1;
    if (!rst && !en) check("stall_hold", int'({out_valid, out_sample}), int'(pre));
    if (!rst && en && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else check("stream_value", int'($signed(out_sample)), exp_q.pop_front());
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic iv, input logic rs,
                     input logic [7:0] px, input logic ev, input int es);
    vec_t v;
    v.rst = rst; v.en = en; v.iv = iv; v.rs = rs; v.px = px; v.ev = ev; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic pix(input logic rs, input logic [7:0] px, input logic ev, input int es);
    add(1'b0, 1'b1, 1'b1, rs, px, ev, es);
  endtask

  task automatic bub(input logic ev, input int es);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, ev, es);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; row_start = 1'b0; in_pixel = 8'd0;

    // Reset state
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    // Flat row of 8 x 100: outputs on edges 3,4,5 after the 6th pixel
    pix(1'b1, 8'd100, 1'b0, 0);
    for (int i = 0; i < 7; i++) pix(1'b0, 8'd100, 1'b0, 0);
    bub(1'b1, 100); bub(1'b1, 100); bub(1'b1, 100); bub(1'b0, 100);
    // Peak
    pix(1'b1, 8'd0, 1'b0, 100);  pix(1'b0, 8'd0, 1'b0, 100);
    pix(1'b0, 8'd255, 1'b0, 100); pix(1'b0, 8'd255, 1'b0, 100);
    pix(1'b0, 8'd0, 1'b0, 100);  pix(1'b0, 8'd0, 1'b0, 100);
    bub(1'b0, 100); bub(1'b0, 100); bub(1'b1, 319); bub(1'b0, 319);
    // Negative lobe
    pix(1'b1, 8'd255, 1'b0, 319); pix(1'b0, 8'd255, 1'b0, 319);
    pix(1'b0, 8'd0, 1'b0, 319);   pix(1'b0, 8'd0, 1'b0, 319);
    pix(1'b0, 8'd255, 1'b0, 319); pix(1'b0, 8'd255, 1'b0, 319);
    bub(1'b0, 319); bub(1'b0, 319); bub(1'b1, -64); bub(1'b0, -64);
    // Row restart: no mixed window
    pix(1'b1, 8'd200, 1'b0, -64);
    for (int i = 0; i < 3; i++) pix(1'b0, 8'd200, 1'b0, -64);
    pix(1'b1, 8'd10, 1'b0, -64);
    for (int i = 0; i < 5; i++) pix(1'b0, 8'd10, 1'b0, -64);
    bub(1'b0, -64); bub(1'b0, -64); bub(1'b1, 10); bub(1'b0, 10);
    // Reset mid-row, then a fresh row
    pix(1'b1, 8'd77, 1'b0, 10);
    for (int i = 0; i < 4; i++) pix(1'b0, 8'd77, 1'b0, 10);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    pix(1'b1, 8'd30, 1'b0, 0);
    for (int i = 0; i < 5; i++) pix(1'b0, 8'd30, 1'b0, 0);
    bub(1'b0, 0); bub(1'b0, 0); bub(1'b1, 30); bub(1'b0, 30);
    // row_start on every pixel never emits
    for (int i = 0; i < 8; i++) pix(1'b1, 8'd99, 1'b0, 30);
    bub(1'b0, 30); bub(1'b0, 30); bub(1'b0, 30);
    // Back-to-back rows: 7 x 60 then immediately 6 x 40
    pix(1'b1, 8'd60, 1'b0, 30);
    for (int i = 0; i < 6; i++) pix(1'b0, 8'd60, 1'b0, 30);
    pix(1'b1, 8'd40, 1'b0, 30);
    pix(1'b0, 8'd40, 1'b1, 60); pix(1'b0, 8'd40, 1'b1, 60);
    pix(1'b0, 8'd40, 1'b0, 60); pix(1'b0, 8'd40, 1'b0, 60); pix(1'b0, 8'd40, 1'b0, 60);
    bub(1'b0, 60); bub(1'b0, 60); bub(1'b1, 40); bub(1'b0, 40);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].iv, vecs[k].rs, vecs[k].px);
      check($sformatf("vec%0d_valid", k), int'(out_valid), int'(vecs[k].ev));
      check($sformatf("vec%0d_sample", k), int'($signed(out_sample)), vecs[k].es);
    end

    // Stall mid-pipe with an input gap, flat row of 50
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd50);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd50);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd50);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("stall_pre_valid", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd99);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("stall_drain", exp_q.size(), 0);
    check("stall_last_sample", int'($signed(out_sample)), 50);

    // Randomized traffic against the row model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] px;
      px = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0)
                                       : 8'($urandom);
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           px);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("random_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
